// File: rtl/axi_slave_pkg.sv
// Shared definitions for the AXI slave write path: state encoding, response and burst codes.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WDATA = 2'b01,
        ST_BRESP = 2'b10
    } wr_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_slave_write_state_core.sv
// AXI write-channel slave controller: accepts one burst at a time, streams beats to a local sink,
// and returns a B response.
//
// state | meaning
// IDLE  | waiting for a write address; awready high
// WDATA | accepting data beats while the local sink is ready
// BRESP | holding bvalid/bresp/bid until the master takes the response
module axi_slave_write_state_core
    import axi_slave_pkg::*;
#(
    parameter int IDSIZE = 3,
    parameter int LSIZE  = 10,
    parameter int ASIZE  = 32
) (
    input  logic              axi_aclk,
    input  logic              axi_resetn,
    input  logic [IDSIZE-1:0] axi_awid,
    input  logic [ASIZE-1:0]  axi_awaddr,
    input  logic [LSIZE-1:0]  axi_awlen,
    input  logic [2:0]        axi_awsize,
    input  logic [1:0]        axi_awburst,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic              axi_wvalid,
    input  logic              axi_wlast,
    output logic              axi_wready,
    output logic [IDSIZE-1:0] axi_bid,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic              local_ready,
    output logic              wr_en,
    output logic [ASIZE-1:0]  wr_addr,
    output logic              wr_last,
    output logic              burst_start,
    output logic              burst_done,
    output logic              burst_err
);

    wr_state_t          state;
    logic [ASIZE-1:0]   addr_q;
    logic [LSIZE-1:0]   awlen_q;
    logic [LSIZE-1:0]   beat_cnt;
    logic [2:0]         awsize_q;
    logic [1:0]         awburst_q;
    logic               err_sticky;
    logic               beat_ok;
    logic               bad_burst;

    assign axi_wready = (state == ST_WDATA) & local_ready;
    assign wr_en      = axi_wvalid & axi_wready;
    assign wr_addr    = addr_q;
    assign wr_last    = axi_wlast & wr_en;
    assign bad_burst  = (awburst_q == BURST_WRAP) | (awburst_q == 2'b11);
    assign beat_ok    = (beat_cnt == awlen_q);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state       <= ST_IDLE;
            axi_awready <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            axi_bid     <= '0;
            addr_q      <= '0;
            awlen_q     <= '0;
            beat_cnt    <= '0;
            awsize_q    <= '0;
            awburst_q   <= BURST_FIXED;
            err_sticky  <= 1'b0;
            burst_start <= 1'b0;
            burst_done  <= 1'b0;
            burst_err   <= 1'b0;
        end else begin
            burst_start <= 1'b0;
            burst_done  <= 1'b0;
            burst_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (axi_awvalid && axi_awready) begin
                        axi_awready <= 1'b0;
                        axi_bid     <= axi_awid;
                        addr_q      <= axi_awaddr;
                        awlen_q     <= axi_awlen;
                        awsize_q    <= axi_awsize;
                        awburst_q   <= axi_awburst;
                        beat_cnt    <= '0;
                        err_sticky  <= 1'b0;
                        burst_start <= 1'b1;
                        state       <= ST_WDATA;
                    end else begin
                        axi_awready <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (wr_en) begin
                        if (awburst_q == BURST_INCR)
                            addr_q <= addr_q + (ASIZE'(1) << awsize_q);
                        if (axi_wlast) begin
                            axi_bresp  <= (err_sticky || !beat_ok || bad_burst) ? RESP_SLVERR : RESP_OKAY;
                            axi_bvalid <= 1'b1;
                            state      <= ST_BRESP;
                        end else if (beat_ok) begin
                            // last expected beat without wlast: flag it and hold the counter
                            err_sticky <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + LSIZE'(1);
                        end
                    end
                end
                ST_BRESP: begin
                    if (axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                        burst_done  <= 1'b1;
                        burst_err   <= (axi_bresp == RESP_SLVERR);
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    axi_awready <= 1'b0;
                    axi_bvalid  <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_write_state_core.sv
// Directed bench for axi_slave_write_state_core; inputs driven and outputs sampled on the falling edge.
module tb_axi_slave_write_state_core;

    localparam int IDSIZE = 3;
    localparam int LSIZE  = 10;
    localparam int ASIZE  = 32;

    logic              axi_aclk = 1'b0;
    logic              axi_resetn;
    logic [IDSIZE-1:0] axi_awid;
    logic [ASIZE-1:0]  axi_awaddr;
    logic [LSIZE-1:0]  axi_awlen;
    logic [2:0]        axi_awsize;
    logic [1:0]        axi_awburst;
    logic              axi_awvalid;
    logic              axi_awready;
    logic              axi_wvalid;
    logic              axi_wlast;
    logic              axi_wready;
    logic [IDSIZE-1:0] axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic              local_ready;
    logic              wr_en;
    logic [ASIZE-1:0]  wr_addr;
    logic              wr_last;
    logic              burst_start;
    logic              burst_done;
    logic              burst_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_slave_write_state_core #(
        .IDSIZE(IDSIZE), .LSIZE(LSIZE), .ASIZE(ASIZE)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .local_ready(local_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_last(wr_last),
        .burst_start(burst_start), .burst_done(burst_done), .burst_err(burst_err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge axi_aclk);
    endtask

    task automatic send_aw(input logic [IDSIZE-1:0] id, input logic [ASIZE-1:0] addr,
                           input logic [LSIZE-1:0] len, input logic [2:0] size, input logic [1:0] burst);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        axi_awvalid = 1'b1;
        #1 check_val("aw_awready", axi_awready, 1'b1);
        tick();
        axi_awvalid = 1'b0;
        #1;
        check_val("aw_burst_start", burst_start, 1'b1);
        check_val("aw_awready_low", axi_awready, 1'b0);
    endtask

    task automatic beat(input string tag, input logic last, input logic [ASIZE-1:0] exp_addr);
        axi_wvalid = 1'b1; axi_wlast = last; local_ready = 1'b1;
        #1;
        check_val({tag, "_wready"}, axi_wready, 1'b1);
        check_val({tag, "_wr_en"}, wr_en, 1'b1);
        check_val({tag, "_wr_addr"}, wr_addr, exp_addr);
        check_val({tag, "_wr_last"}, wr_last, last);
        check_val({tag, "_bvalid_low"}, axi_bvalid, 1'b0);
        tick();
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic take_b(input string tag, input logic [1:0] exp_resp, input logic [IDSIZE-1:0] exp_id);
        #1;
        check_val({tag, "_bvalid"}, axi_bvalid, 1'b1);
        check_val({tag, "_bresp"}, axi_bresp, exp_resp);
        check_val({tag, "_bid"}, axi_bid, exp_id);
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        #1;
        check_val({tag, "_bvalid_drop"}, axi_bvalid, 1'b0);
        check_val({tag, "_burst_done"}, burst_done, 1'b1);
        check_val({tag, "_burst_err"}, burst_err, exp_resp == 2'b10);
        check_val({tag, "_awready_back"}, axi_awready, 1'b1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_resetn = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b0;
        local_ready = 1'b0;
        tick(); tick();
        check_val("rst_awready", axi_awready, 1'b0);
        check_val("rst_bvalid", axi_bvalid, 1'b0);
        check_val("rst_bresp", axi_bresp, 2'b00);
        check_val("rst_bid", axi_bid, 3'd0);
        check_val("rst_wr_addr", wr_addr, 32'h0);
        axi_resetn = 1'b1;
        tick();
        check_val("rel_awready", axi_awready, 1'b1);

        // INCR, 4 beats of 32 bytes
        send_aw(3'd5, 32'h1000, 10'd3, 3'd5, 2'b01);
        beat("incr0", 1'b0, 32'h1000);
        beat("incr1", 1'b0, 32'h1020);
        beat("incr2", 1'b0, 32'h1040);
        beat("incr3", 1'b1, 32'h1060);
        take_b("incr_b", 2'b00, 3'd5);

        // FIXED, 2 beats
        send_aw(3'd2, 32'h2004, 10'd1, 3'd2, 2'b00);
        beat("fix0", 1'b0, 32'h2004);
        beat("fix1", 1'b1, 32'h2004);
        take_b("fix_b", 2'b00, 3'd2);

        // early wlast on beat 2 of 4
        send_aw(3'd7, 32'h3000, 10'd3, 3'd2, 2'b01);
        beat("early0", 1'b0, 32'h3000);
        beat("early1", 1'b1, 32'h3004);
        take_b("early_b", 2'b10, 3'd7);

        // local_ready 1,0,1 then bready held low
        send_aw(3'd1, 32'h4000, 10'd1, 3'd0, 2'b01);
        beat("lr0", 1'b0, 32'h4000);
        axi_wvalid = 1'b1; local_ready = 1'b0;
        #1;
        check_val("lr_stall_wready", axi_wready, 1'b0);
        check_val("lr_stall_wr_en", wr_en, 1'b0);
        tick();
        beat("lr1", 1'b1, 32'h4001);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("hold_bvalid", axi_bvalid, 1'b1);
            check_val("hold_bresp", axi_bresp, 2'b00);
            check_val("hold_bid", axi_bid, 3'd1);
            check_val("hold_awready", axi_awready, 1'b0);
            tick();
        end
        take_b("lr_b", 2'b00, 3'd1);

        // missing last: awlen=1 but wlast only on the third beat
        send_aw(3'd3, 32'h0010, 10'd1, 3'd0, 2'b01);
        beat("miss0", 1'b0, 32'h0010);
        beat("miss1", 1'b0, 32'h0011);
        beat("miss2", 1'b1, 32'h0012);
        take_b("miss_b", 2'b10, 3'd3);

        // unsupported WRAP burst: beats consumed, address held
        send_aw(3'd4, 32'h5000, 10'd1, 3'd2, 2'b10);
        beat("wrap0", 1'b0, 32'h5000);
        beat("wrap1", 1'b1, 32'h5000);
        take_b("wrap_b", 2'b10, 3'd4);

        // reset mid-WDATA
        send_aw(3'd6, 32'h6000, 10'd3, 3'd2, 2'b01);
        beat("mid0", 1'b0, 32'h6000);
        axi_wvalid = 1'b1; local_ready = 1'b1;
        axi_resetn = 1'b0;
        #1;
        check_val("mid_rst_wready", axi_wready, 1'b0);
        check_val("mid_rst_wr_en", wr_en, 1'b0);
        check_val("mid_rst_bvalid", axi_bvalid, 1'b0);
        check_val("mid_rst_awready", axi_awready, 1'b0);
        check_val("mid_rst_bid", axi_bid, 3'd0);
        check_val("mid_rst_wr_addr", wr_addr, 32'h0);
        check_val("mid_rst_start", burst_start, 1'b0);
        tick(); tick();
        axi_wvalid = 1'b0;
        axi_resetn = 1'b1;
        tick();
        check_val("post_rst_awready", axi_awready, 1'b1);
        check_val("post_rst_bvalid", axi_bvalid, 1'b0);
        check_val("post_rst_done", burst_done, 1'b0);
        tick();
        check_val("post_rst_bvalid2", axi_bvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
